// File: rtl/alu_pkg.sv
// Opcodes, flag bit positions and a width helper for the ALU / CONV execute unit.
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_CONV = 3'b111;

  localparam int FLAG_V   = 0;
  localparam int FLAG_C   = 1;
  localparam int FLAG_Z   = 2;
  localparam int FLAG_N   = 3;
  localparam int FLAG_CNT = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/alu_conv_unit_if.sv
// Operand/result handshake bundle between the execute stage and alu_conv_unit.
interface alu_conv_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] Result;
  logic             OverFlow;
  logic             Carry;
  logic             Zero;
  logic             Negative;

  modport master (
    output in_valid, ALUControl, A, B, res_ready,
    input  in_ready, res_valid, Result, OverFlow, Carry, Zero, Negative
  );

  modport slave (
    input  in_valid, ALUControl, A, B, res_ready,
    output in_ready, res_valid, Result, OverFlow, Carry, Zero, Negative
  );
endinterface

// File: rtl/alu_core.sv
// Combinational integer ALU: ADD/SUB/AND/OR/XOR/SLT/SLTU with V/C/Z/N flags.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]          op_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  output logic [WIDTH-1:0]    result_o,
  output logic [FLAG_CNT-1:0] flags_o
);

  logic             sub_mode;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  always_comb begin
    // SLT/SLTU reuse the subtractor so compare semantics track SUB exactly
    sub_mode     = (op_i == ALU_SUB) || (op_i == ALU_SLT) || (op_i == ALU_SLTU);
    b_eff        = sub_mode ? ~b_i : b_i;
    {cout, sum}  = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
    ovf          = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

    result_o = '0;
    flags_o  = '0;
    case (op_i)
      ALU_ADD, ALU_SUB: begin
        result_o        = sum;
        flags_o[FLAG_V] = ovf;
        flags_o[FLAG_C] = cout;
      end
      ALU_AND:  result_o = a_i & b_i;
      ALU_OR:   result_o = a_i | b_i;
      ALU_XOR:  result_o = a_i ^ b_i;
      ALU_SLT:  result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      ALU_SLTU: result_o = {{(WIDTH-1){1'b0}}, ~cout};
      default:  result_o = '0;
    endcase
    flags_o[FLAG_Z] = (result_o == '0);
    flags_o[FLAG_N] = result_o[WIDTH-1];
  end

endmodule

// File: rtl/alu_conv_unit.sv
// Registered execute-stage ALU with a TAPS-beat signed MAC (CONV) mode behind a valid/ready handshake.
// One-entry output register; a new beat may be accepted in the cycle the held result is consumed.
module alu_conv_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAPS  = 9,
  parameter bit SAT   = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  alu_conv_unit_if.slave  bus,
  output logic            busy,
  output logic            conv_abort
);

  localparam int ACC_W = (TAPS > 1) ? 2*WIDTH + clog2(TAPS) : 2*WIDTH;
  localparam int CNT_W = (TAPS > 1) ? clog2(TAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

  typedef enum logic {S_IDLE, S_ACCUM} state_e;

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           tap_cnt_q, tap_cnt_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       res_valid_q, res_valid_d;
  logic [WIDTH-1:0]           result_q, result_d;
  logic [FLAG_CNT-1:0]        flags_q, flags_d;
  logic                       abort_q, abort_d;

  logic [WIDTH-1:0]           core_res;
  logic [FLAG_CNT-1:0]        core_flags;
  logic signed [2*WIDTH-1:0]  prod;
  logic signed [ACC_W-1:0]    acc_base;
  logic signed [ACC_W-1:0]    acc_next;
  logic [ACC_W-WIDTH:0]       acc_hi;
  logic                       conv_ovf;
  logic [WIDTH-1:0]           conv_res;
  logic                       accept;
  logic                       is_conv;
  logic                       last_tap;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op_i     (bus.ALUControl),
    .a_i      (bus.A),
    .b_i      (bus.B),
    .result_o (core_res),
    .flags_o  (core_flags)
  );

  assign bus.in_ready = !res_valid_q || bus.res_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_conv      = (bus.ALUControl == ALU_CONV);
  assign last_tap     = (tap_cnt_q == LAST_TAP);

  // Operands are sign-extended first so the low 2*WIDTH bits hold the exact signed product
  assign prod     = (2*WIDTH)'($signed(bus.A)) * (2*WIDTH)'($signed(bus.B));
  assign acc_base = (state_q == S_IDLE) ? '0 : acc_q;
  assign acc_next = acc_base + ACC_W'(prod);

  always_comb begin
    // In range iff every bit from WIDTH-1 upward matches the sign
    acc_hi   = acc_next[ACC_W-1:WIDTH-1];
    conv_ovf = !((&acc_hi) || !(|acc_hi));
    if (SAT && conv_ovf) begin
      conv_res = acc_next[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      conv_res = acc_next[WIDTH-1:0];
    end
  end

  always_comb begin
    tap_cnt_d   = tap_cnt_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q && !bus.res_ready;
    result_d    = result_q;
    flags_d     = flags_q;
    abort_d     = 1'b0;

    if (accept) begin
      if (is_conv) begin
        acc_d = acc_next;
        if (last_tap) begin
          tap_cnt_d        = '0;
          res_valid_d      = 1'b1;
          result_d         = conv_res;
          flags_d          = '0;
          flags_d[FLAG_V]  = conv_ovf;
          flags_d[FLAG_Z]  = (conv_res == '0);
          flags_d[FLAG_N]  = conv_res[WIDTH-1];
        end else begin
          tap_cnt_d = tap_cnt_q + 1'b1;
        end
      end else begin
        abort_d     = (state_q == S_ACCUM);
        tap_cnt_d   = '0;
        acc_d       = '0;
        res_valid_d = 1'b1;
        result_d    = core_res;
        flags_d     = core_flags;
      end
    end

    state_d = (tap_cnt_d != '0) ? S_ACCUM : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tap_cnt_q   <= '0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tap_cnt_q   <= tap_cnt_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.Result    = result_q;
  assign bus.OverFlow  = flags_q[FLAG_V];
  assign bus.Carry     = flags_q[FLAG_C];
  assign bus.Zero      = flags_q[FLAG_Z];
  assign bus.Negative  = flags_q[FLAG_N];
  assign busy          = (tap_cnt_q != '0);
  assign conv_abort    = abort_q;

endmodule

// File: tb/tb_alu_conv_unit.sv
// Bench for alu_conv_unit: directed cases plus random traffic against an arithmetic reference model.
module tb_alu_conv_unit;
  import alu_pkg::*;

  localparam int W     = 32;
  localparam int TAPS9 = 9;

  typedef struct packed {
    logic        v;
    logic        c;
    logic        z;
    logic        n;
    logic [31:0] res;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_conv_unit_if #(.WIDTH(W)) if9 ();
  alu_conv_unit_if #(.WIDTH(W)) if1s ();
  alu_conv_unit_if #(.WIDTH(W)) if1t ();

  logic busy9, abort9, busy1s, abort1s, busy1t, abort1t;

  alu_conv_unit #(.WIDTH(W), .TAPS(TAPS9), .SAT(1'b1)) u_dut9 (
    .clk(clk), .rst(rst), .bus(if9.slave), .busy(busy9), .conv_abort(abort9));
  alu_conv_unit #(.WIDTH(W), .TAPS(1), .SAT(1'b1)) u_dut1s (
    .clk(clk), .rst(rst), .bus(if1s.slave), .busy(busy1s), .conv_abort(abort1s));
  alu_conv_unit #(.WIDTH(W), .TAPS(1), .SAT(1'b0)) u_dut1t (
    .clk(clk), .rst(rst), .bus(if1t.slave), .busy(busy1t), .conv_abort(abort1t));

  logic         t1_vld;
  logic [2:0]   t1_op;
  logic [W-1:0] t1_a, t1_b;

  assign if1s.in_valid   = t1_vld;
  assign if1s.ALUControl = t1_op;
  assign if1s.A          = t1_a;
  assign if1s.B          = t1_b;
  assign if1s.res_ready  = 1'b1;
  assign if1t.in_valid   = t1_vld;
  assign if1t.ALUControl = t1_op;
  assign if1t.A          = t1_a;
  assign if1t.B          = t1_b;
  assign if1t.res_ready  = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the TAPS=9 unit: held result plus the products of the CONV beats seen so far
  bit          m_rv;
  logic [31:0] m_res;
  bit          m_v, m_c, m_z, m_n, m_abort;
  longint      m_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic out_t ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    out_t   o;
    longint su, ss;
    int     sa, sb;
    sa = a;
    sb = b;
    o  = '0;
    su = 0;
    ss = 0;
    case (op)
      ALU_ADD: begin
        su = {32'b0, a} + {32'b0, b};
        ss = longint'(sa) + longint'(sb);
        o.res = su[31:0];
        o.c = su[32];
        o.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      ALU_SUB: begin
        su = {32'b0, a} + {32'b0, ~b} + 64'd1;
        ss = longint'(sa) - longint'(sb);
        o.res = su[31:0];
        o.c = su[32];
        o.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      ALU_AND:  o.res = a & b;
      ALU_OR:   o.res = a | b;
      ALU_XOR:  o.res = a ^ b;
      ALU_SLT:  o.res = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: o.res = (a < b) ? 32'd1 : 32'd0;
      default:  o.res = 32'd0;
    endcase
    o.z = (o.res == 32'd0);
    o.n = o.res[31];
    return o;
  endfunction

  function automatic out_t ref_conv(input logic signed [127:0] s, input bit sat);
    out_t o;
    o   = '0;
    o.v = (s > 128'sd2147483647) || (s < -128'sd2147483648);
    if (o.v && sat) o.res = (s < 0) ? 32'h8000_0000 : 32'h7fff_ffff;
    else            o.res = s[31:0];
    o.z = (o.res == 32'd0);
    o.n = o.res[31];
    return o;
  endfunction

  task automatic model_clear();
    m_rv = 0; m_res = '0; m_v = 0; m_c = 0; m_z = 0; m_n = 0; m_abort = 0;
    m_q.delete();
  endtask

  // One cycle on the TAPS=9 unit: drive, check what the model expects now, then advance the model
  task automatic cyc9(input bit vld, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input bit rdy);
    bit                   exp_rdy;
    out_t                 o;
    int                   sa, sb;
    logic signed [127:0]  s;
    @(negedge clk);
    if9.in_valid   = vld;
    if9.ALUControl = op;
    if9.A          = a;
    if9.B          = b;
    if9.res_ready  = rdy;
    #1;
    exp_rdy = !m_rv || rdy;
    check("in_ready", if9.in_ready, exp_rdy);
    check("res_valid", if9.res_valid, m_rv);
    if (m_rv) begin
      check("result", if9.Result, m_res);
      check("flags_vczn", {if9.OverFlow, if9.Carry, if9.Zero, if9.Negative}, {m_v, m_c, m_z, m_n});
    end
    check("busy", busy9, m_q.size() != 0);
    check("conv_abort", abort9, m_abort);

    m_abort = 0;
    if (m_rv && rdy) m_rv = 0;
    if (vld && exp_rdy) begin
      o = '0;
      if (op == ALU_CONV) begin
        sa = a;
        sb = b;
        m_q.push_back(longint'(sa) * longint'(sb));
        if (m_q.size() == TAPS9) begin
          s = '0;
          foreach (m_q[i]) s = s + 128'(m_q[i]);
          o = ref_conv(s, 1'b1);
          m_q.delete();
          m_rv = 1;
          {m_v, m_c, m_z, m_n, m_res} = o;
        end
      end else begin
        m_abort = (m_q.size() != 0);
        m_q.delete();
        o = ref_alu(op, a, b);
        m_rv = 1;
        {m_v, m_c, m_z, m_n, m_res} = o;
      end
    end
  endtask

  // One accepted beat on both TAPS=1 units, checked one cycle later
  task automatic beat1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    out_t                 os, ot;
    int                   sa, sb;
    logic signed [127:0]  s;
    @(negedge clk);
    t1_vld = 1'b1; t1_op = op; t1_a = a; t1_b = b;
    @(negedge clk);
    t1_vld = 1'b0;
    #1;
    if (op == ALU_CONV) begin
      sa = a;
      sb = b;
      s  = 128'(longint'(sa) * longint'(sb));
      os = ref_conv(s, 1'b1);
      ot = ref_conv(s, 1'b0);
    end else begin
      os = ref_alu(op, a, b);
      ot = os;
    end
    check("t1s_valid", if1s.res_valid, 1'b1);
    check("t1s_out", {if1s.OverFlow, if1s.Carry, if1s.Zero, if1s.Negative, if1s.Result}, os);
    check("t1t_valid", if1t.res_valid, 1'b1);
    check("t1t_out", {if1t.OverFlow, if1t.Carry, if1t.Zero, if1t.Negative, if1t.Result}, ot);
    check("t1_busy_abort", {busy1s, abort1s, busy1t, abort1t}, 4'b0);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 3))
      0:       return 32'($urandom_range(0, 15));
      1:       return 32'hffff_fff0 | 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [2:0] op;
    if9.in_valid = 0; if9.ALUControl = '0; if9.A = '0; if9.B = '0; if9.res_ready = 1;
    t1_vld = 0; t1_op = '0; t1_a = '0; t1_b = '0;
    model_clear();

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_result", if9.Result, 32'd0);
    check("rst_flags", {if9.OverFlow, if9.Carry, if9.Zero, if9.Negative}, 4'b0);
    check("rst_res_valid", if9.res_valid, 1'b0);
    check("rst_busy_abort", {busy9, abort9}, 2'b0);
    check("rst_in_ready", if9.in_ready, 1'b1);

    // Signed overflow on ADD
    cyc9(1, ALU_ADD, 32'h7fff_ffff, 32'd1, 1);
    cyc9(0, ALU_ADD, 32'd0, 32'd0, 1);
    check("add_res", if9.Result, 32'h8000_0000);
    check("add_vcn", {if9.OverFlow, if9.Carry, if9.Negative}, 3'b101);

    // Back-to-back SUB / SLT / SLTU / XOR; each result appears while the next op is accepted
    cyc9(1, ALU_SUB, 32'd5, 32'd5, 1);
    cyc9(1, ALU_SLT, 32'hffff_ffff, 32'd1, 1);
    check("sub_res_zc", {if9.Result, if9.Zero, if9.Carry}, {32'd0, 2'b11});
    cyc9(1, ALU_SLTU, 32'hffff_ffff, 32'd1, 1);
    check("slt_res", if9.Result, 32'd1);
    cyc9(1, ALU_XOR, 32'hf0f0_f0f0, 32'hff00_ff00, 1);
    check("sltu_res", if9.Result, 32'd0);
    cyc9(0, ALU_ADD, 32'd0, 32'd0, 1);
    check("xor_res", if9.Result, 32'h0ff0_0ff0);

    // Nine-tap CONV
    for (int i = 1; i <= 9; i++) cyc9(1, ALU_CONV, 32'(i), 32'd2, 1);
    check("conv_no_early_result", if9.res_valid, 1'b0);
    cyc9(0, ALU_ADD, 32'd0, 32'd0, 1);
    check("conv_res", {if9.res_valid, if9.Result, if9.OverFlow}, {1'b1, 32'd90, 1'b0});

    // Backpressure: result held, then consume and accept in the same cycle
    cyc9(1, ALU_ADD, 32'd3, 32'd4, 1);
    repeat (5) cyc9(1, ALU_OR, 32'h55, 32'haa, 0);
    check("bp_hold", {if9.in_ready, if9.Result}, {1'b0, 32'd7});
    cyc9(1, ALU_OR, 32'h55, 32'haa, 1);
    cyc9(0, ALU_ADD, 32'd0, 32'd0, 1);
    check("bp_next_res", if9.Result, 32'hff);

    // Abort a partial CONV, then a fresh CONV with no carry-over
    for (int i = 0; i < 4; i++) cyc9(1, ALU_CONV, rnd_operand(), rnd_operand(), 1);
    cyc9(1, ALU_AND, 32'hff, 32'h0f, 1);
    cyc9(0, ALU_ADD, 32'd0, 32'd0, 1);
    check("abort_pulse_res", {abort9, if9.Result}, {1'b1, 32'h0f});
    for (int i = 1; i <= 9; i++) cyc9(1, ALU_CONV, 32'(i), 32'hffff_ffff, 1);
    cyc9(0, ALU_ADD, 32'd0, 32'd0, 1);
    check("fresh_conv_res", {abort9, if9.Result}, {1'b0, 32'hffff_ffd3});

    // Random traffic with random backpressure
    for (int i = 0; i < 1500; i++) begin
      op = ($urandom_range(0, 99) < 85) ? ALU_CONV : 3'($urandom_range(0, 6));
      cyc9($urandom_range(0, 99) < 80, op, rnd_operand(), rnd_operand(), $urandom_range(0, 99) < 75);
    end

    // Reset in the middle of an accumulation
    cyc9(1, ALU_ADD, 32'd0, 32'd0, 1);
    for (int i = 0; i < 3; i++) cyc9(1, ALU_CONV, 32'd3, 32'd4, 1);
    cyc9(0, ALU_ADD, 32'd0, 32'd0, 1);
    check("pre_rst_busy", busy9, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    if9.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_busy_valid_abort", {busy9, if9.res_valid, abort9}, 3'b000);
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 9; i++) cyc9(1, ALU_CONV, 32'(i), 32'd7, 1);
    cyc9(0, ALU_ADD, 32'd0, 32'd0, 1);
    check("post_rst_conv", if9.Result, 32'd252);

    // TAPS=1: saturating vs truncating CONV
    beat1(ALU_CONV, 32'h7fff_ffff, 32'h7fff_ffff);
    check("sat_res_ovf", {if1s.Result, if1s.OverFlow}, {32'h7fff_ffff, 1'b1});
    check("trunc_res_ovf", {if1t.Result, if1t.OverFlow}, {32'h0000_0001, 1'b1});
    beat1(ALU_CONV, 32'h8000_0000, 32'h7fff_ffff);
    check("sat_neg_res", if1s.Result, 32'h8000_0000);
    beat1(ALU_CONV, 32'hffff_fffd, 32'd5);
    check("conv_small_neg", {if1s.Result, if1s.OverFlow}, {32'hffff_fff1, 1'b0});
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 1) == 1) ? ALU_CONV : 3'($urandom_range(0, 6));
      beat1(op, rnd_operand(), rnd_operand());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_conv_unit.md
Name: alu_conv_unit

Overview:
- Parametrised, registered successor to the pipeline's combinational ALU.
- Executes the RISC-V integer ops, plus a multi-cycle signed multiply-accumulate mode (CONV) that reduces a TAPS-long stream of pixel/weight pairs to one result for the CNN datapath.
- Sits in the execute stage.
- Uses a valid/ready handshake with a one-entry output register that supports backpressure.

Parameters:
- WIDTH, 32: operand/result width.
- TAPS, 9: number of MAC beats per CONV result (>=1).
- SAT, 1: 1 = CONV result saturates to the signed WIDTH range; 0 = truncates to the low WIDTH bits.
- ACC_W (localparam): 2*WIDTH + clog2(TAPS) when TAPS>1, 2*WIDTH when TAPS=1; accumulator width.

Ports:
- clk  in  1  clock, all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat.
- ALUControl  in  3  opcode.
- A  in  WIDTH  operand A (pixel in CONV).
- B  in  WIDTH  operand B (weight in CONV).
- res_valid  out  1  result register holds a valid result.
- res_ready  in  1  consumer accepts the result.
- Result  out  WIDTH  registered result.
- OverFlow  out  1  registered flag.
- Carry  out  1  registered flag.
- Zero  out  1  registered flag.
- Negative  out  1  registered flag.
- busy  out  1  CONV accumulation in progress (tap_cnt != 0).
- conv_abort  out  1  one-cycle pulse: partial CONV discarded.

Behaviour:
- Reset (synchronous, active-high): res_valid, Result, all flags, acc, tap_cnt and conv_abort all go to 0. Reset mid-CONV discards the partial sum with no conv_abort pulse.
- Ready/accept:
  - in_ready = !res_valid || res_ready. This is combinational and independent of in_valid.
  - A beat is accepted when in_valid && in_ready.
  - Result and flags are held stable while res_valid && !res_ready.
- Opcodes:
  - 000 ADD
  - 001 SUB (A + ~B + 1)
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SLT (signed; result = Sum[msb] ^ overflow, zero-extended)
  - 110 SLTU (result = !carry-out of SUB)
  - 111 CONV
- Non-CONV latency: an op accepted in cycle t drives Result/flags with res_valid=1 in cycle t+1.
- Flags, non-CONV:
  - OverFlow: signed overflow for ADD/SUB, else 0.
  - Carry: carry-out of the adder for ADD/SUB, else 0.
  - Zero: Result == 0.
  - Negative: Result[WIDTH-1].
- CONV FSM:
  - States: IDLE (tap_cnt=0) and ACCUM (0 < tap_cnt < TAPS).
  - Each accepted CONV beat: acc_next = (tap_cnt==0 ? 0 : acc) + $signed(A)*$signed(B), computed at ACC_W width. acc <= acc_next.
  - Non-final beat: tap_cnt increments and no result is produced.
  - Final beat (tap_cnt == TAPS-1):
    - Result is loaded from acc_next (saturated or truncated per SAT).
    - res_valid=1 next cycle; tap_cnt returns to 0.
    - OverFlow=1 iff acc_next lies outside the signed WIDTH range, regardless of SAT.
    - Carry=0; Zero and Negative are taken from Result.
  - TAPS=1: every CONV beat produces a result with 1-cycle latency.
- Abort: a non-CONV op accepted while in ACCUM clears tap_cnt and acc and pulses conv_abort the next cycle. The op itself executes normally.
- Back-to-back: a new beat may be accepted in the same cycle the result is consumed (res_ready=1), so full throughput is one op per cycle.
- Wrap-around: tap_cnt never exceeds TAPS-1. acc is never reused across results.

Decomposition:
- Package alu_pkg:
  - Opcode localparams ALU_ADD…ALU_CONV.
  - Flag bit-index constants.
  - clog2 function.
- One sub-module, alu_core: combinational ADD/SUB/logic/SLT/SLTU with flag generation.
- alu_conv_unit owns the handshake, the FSM, the accumulator and the output register.

Test Plan:
- ADD with A=0x7FFFFFFF, B=1 → Result 0x80000000, OverFlow=1, Negative=1, Carry=0, res_valid exactly 1 cycle after accept.
- SUB with A=5, B=5 → Result 0, Zero=1, Carry=1. Then A=0xFFFFFFFF, B=1: SLT → 1, SLTU → 0; XOR with A=0xF0F0F0F0, B=0xFF00FF00 → 0x0FF00FF0.
- CONV, TAPS=9, beats A=1..9, B=2 → busy high after beat 1 through beat 9, no res_valid until 1 cycle after beat 9, Result=90, OverFlow=0.
- Backpressure: hold res_ready=0 with res_valid=1 → in_ready=0, Result stable 5 cycles. Raise res_ready together with in_valid → consume and accept in the same cycle.
- Abort: 4 CONV beats, then AND with A=0xFF, B=0x0F → conv_abort pulse, Result 0x0F. A fresh 9-beat CONV then sums with no carry-over.
- Saturation: TAPS=1, SAT=1, A=B=0x7FFFFFFF → Result 0x7FFFFFFF, OverFlow=1. Same stimulus with SAT=0 → Result 0x00000001, OverFlow=1. Assert rst mid-ACCUM → busy=0, res_valid=0 next cycle.
